adc_capture_controller: RTL and testbench
=========================================

Name: adc_capture_controller

Overview:
Receive-side counterpart of the DAC output path. Accepts the RFDC ADC AXI4-Stream, starts a capture window when the 64-bit RTIO counter reaches a programmed start time, and buffers a programmed number of 256-bit beats. Buffered beats are presented to the AXI-side reader as a header word followed by 128-bit data words.

Parameters:
AXIS_DATA_WIDTH, 256, ADC stream beat width; must equal 2*OUT_WIDTH
OUT_WIDTH, 128, reader word width; matches the AXI data width
FIFO_DEPTH, 64, capture buffer depth in beats; power of two
LEN_WIDTH, 16, width of the capture length field

Ports:
s_axi_aclk  in  1  single clock for the whole block; the ADC stream is already in this domain
s_axi_aresetn  in  1  asynchronous, active-low reset
counter  in  64  RTIO time counter
cfg_start_time  in  64  capture start timestamp, sampled on arm
cfg_length  in  LEN_WIDTH  number of beats to capture, sampled on arm
arm  in  1  single-cycle pulse that arms a capture
flush  in  1  single-cycle synchronous abort
s00_axis_tdata  in  AXIS_DATA_WIDTH  ADC samples
s00_axis_tvalid  in  1  ADC beat valid
s00_axis_tready  out  1  ready to the ADC stream
rd_data  out  OUT_WIDTH  reader word
rd_valid  out  1  reader word valid
rd_ready  in  1  reader accepts the word
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse after the last word is accepted
timestamp_error  out  1  sticky flag
overflow_error  out  1  sticky flag
dropped_count  out  LEN_WIDTH  beats lost to a full FIFO in the current capture

Behaviour:
- Reset values: s00_axis_tready=0, rd_valid=0, rd_data=0, busy=0, done=0, both error flags=0, dropped_count=0, FIFO empty, state IDLE.
- s00_axis_tready is 1 from the first cycle after reset release; the block never backpressures the ADC.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE -> ARMED on arm:
  - latch start_time and length; clear both error flags and dropped_count.
  - if cfg_length==0, stay IDLE and emit no output.
  - arm while busy is ignored.
- ARMED -> CAPTURE on the first cycle where counter >= start_time and tvalid=1. That beat is the first beat captured.
- Late arm: if counter > start_time on the arm cycle, set timestamp_error and start capturing immediately, by the same rule.
- CAPTURE header: on entry, load the header register with {start_counter[63:0], length[15:0], 48'h0}, where start_counter is the counter value of the first beat.
- CAPTURE beat handling: each cycle with tvalid=1 consumes one beat and increments the beat count.
  - FIFO not full: the beat is pushed.
  - FIFO full: the beat is dropped, overflow_error is set, dropped_count is incremented (saturating).
  - Dropped beats still count toward length.
- CAPTURE -> DRAIN in the cycle after the beat count reaches length.
- Output order: header first, then for each FIFO entry the low half [127:0] followed by the high half [255:128].
  - Header becomes available one cycle after CAPTURE entry.
  - Output runs concurrently with capture.
- Reader handshake: standard valid/ready. rd_data is held stable while rd_valid=1 and rd_ready=0. One word is transferred per cycle when both are high. The FIFO pop happens when the high half is transferred.
- Output register: registered, with one cycle of latency from FIFO non-empty to rd_valid. The output stage sustains full throughput under continuous rd_ready.
- DRAIN -> IDLE when the FIFO is empty and the last word has been transferred. done pulses in the same cycle as the IDLE transition.
- Simultaneous push and pop on a full FIFO: the pop happens first, the push succeeds, and no overflow is flagged.
- flush in any state:
  - next cycle: state IDLE, FIFO emptied, rd_valid=0, header discarded.
  - error flags are kept; done is not pulsed.
  - flush and arm in the same cycle: flush wins.
- Counter wrap is not handled. The comparison is an unsigned 64-bit >=.

Decomposition:
- Shared package: state enum, header field offsets/widths, default parameter constants.
- One sub-module, capture_fifo: synchronous FIFO, AXIS_DATA_WIDTH x FIFO_DEPTH, with push/pop/full/empty/clear and async active-low reset on s_axi_aresetn.

Test Plan:
- Normal capture:
  - Stimulus: arm with start=1000, length=4; counter increments each cycle; tvalid=1 with incrementing data; rd_ready=1.
  - Response: header {1000, 4, 0}, then 8 words in the order low/high of beats 0..3, then done; no errors.
- Late start:
  - Stimulus: arm with start=50 at counter=80, length=2.
  - Response: timestamp_error=1; header timestamp=81 (first valid beat); 4 data words follow.
- Overflow:
  - Stimulus: FIFO_DEPTH=64, length=100, rd_ready=0 throughout capture.
  - Response: overflow_error=1, dropped_count=36; after rd_ready=1, the header plus 128 words drain, then done.
- Reader stall:
  - Stimulus: rd_ready toggles 1/0 every cycle.
  - Response: rd_data is stable during stalls; no words are lost or duplicated; word order is preserved.
- Flush mid-capture:
  - Stimulus: flush after 3 of 10 beats.
  - Response: busy=0 and rd_valid=0 next cycle; no done pulse; a new arm then captures cleanly.
- Guards:
  - Stimulus: arm with length=0; arm while busy.
  - Response: both ignored; no output words; the in-flight capture is unaffected.

Source files
------------

// File: rtl/adc_capture_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_controller_pkg
// Description : Shared types, header layout and default sizes for the ADC
//               capture controller and its capture FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_controller_pkg;

  localparam int DEFAULT_AXIS_DATA_WIDTH = 256;
  localparam int DEFAULT_OUT_WIDTH       = 128;
  localparam int DEFAULT_FIFO_DEPTH      = 64;
  localparam int DEFAULT_LEN_WIDTH       = 16;

  // Header word layout: {timestamp[63:0], length[15:0], 48'h0}
  localparam int HDR_W       = 128;
  localparam int HDR_TS_W    = 64;
  localparam int HDR_LEN_W   = 16;
  localparam int HDR_PAD_W   = 48;
  localparam int HDR_LEN_LSB = HDR_PAD_W;
  localparam int HDR_TS_LSB  = HDR_LEN_LSB + HDR_LEN_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // What the reader output register currently holds
  typedef enum logic [1:0] {
    OUT_NONE = 2'd0,
    OUT_HDR  = 2'd1,
    OUT_LO   = 2'd2,
    OUT_HI   = 2'd3
  } out_kind_t;

  function automatic logic [HDR_W-1:0] make_header(input logic [HDR_TS_W-1:0]  ts,
                                                   input logic [HDR_LEN_W-1:0] len);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_TS_LSB +: HDR_TS_W]   = ts;
    h[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_controller_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_fifo
// Description : Synchronous FIFO for captured ADC beats. A push into a full
//               FIFO succeeds when a pop happens in the same cycle. A second
//               read port peeks the low PEEK_WIDTH bits of the entry behind
//               the head so the reader can stream without bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_fifo #(
  parameter int WIDTH      = 256,
  parameter int DEPTH      = 64,
  parameter int PEEK_WIDTH = 128,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [PEEK_WIDTH-1:0] rdata_next,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign rdata      = mem[rd_ptr_q];
  assign rdata_next = mem[rd_ptr_q + AW'(1)][PEEK_WIDTH-1:0];

  // Pointer and occupancy update; pop frees a slot before the push is judged
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_controller
// Description : Time-triggered ADC stream capture. Starts a window when the
//               RTIO counter reaches the armed start time, buffers the beats
//               and streams a header word plus low/high data halves out.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_controller
  import adc_capture_controller_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEFAULT_AXIS_DATA_WIDTH,
  parameter int OUT_WIDTH       = DEFAULT_OUT_WIDTH,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int LEN_WIDTH       = DEFAULT_LEN_WIDTH
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [63:0]                counter,
  input  logic [63:0]                cfg_start_time,
  input  logic [LEN_WIDTH-1:0]       cfg_length,
  input  logic                       arm,
  input  logic                       flush,
  input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                       s00_axis_tvalid,
  output logic                       s00_axis_tready,
  output logic [OUT_WIDTH-1:0]       rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       timestamp_error,
  output logic                       overflow_error,
  output logic [LEN_WIDTH-1:0]       dropped_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                 state_q, state_d;
  out_kind_t              out_kind_q, out_kind_d;
  logic [63:0]            start_time_q, start_time_d;
  logic [LEN_WIDTH-1:0]   length_q, length_d;
  logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]   dropped_q, dropped_d;
  logic [OUT_WIDTH-1:0]   hdr_q, hdr_d;
  logic [OUT_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                   hdr_pending_q, hdr_pending_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   tready_q, tready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ts_err_q, ts_err_d;
  logic                   ovf_err_q, ovf_err_d;

  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AXIS_DATA_WIDTH-1:0] fifo_rdata;
  logic [OUT_WIDTH-1:0]       fifo_rdata_next;
  logic [CNT_W-1:0]           fifo_count;
  logic                       xfer, load_en, take_beat;

  capture_fifo #(
    .WIDTH      (AXIS_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .PEEK_WIDTH (OUT_WIDTH)
  ) u_capture_fifo (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .clear      (flush),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .wdata      (s00_axis_tdata),
    .rdata      (fifo_rdata),
    .rdata_next (fifo_rdata_next),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Next-state: capture FSM, beat accounting, reader output stage, flush
  always_comb begin
    state_d       = state_q;
    out_kind_d    = out_kind_q;
    start_time_d  = start_time_q;
    length_d      = length_q;
    beat_cnt_d    = beat_cnt_q;
    dropped_d     = dropped_q;
    hdr_d         = hdr_q;
    hdr_pending_d = hdr_pending_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    ts_err_d      = ts_err_q;
    ovf_err_d     = ovf_err_q;
    tready_d      = 1'b1;
    done_d        = 1'b0;
    fifo_push     = 1'b0;
    take_beat     = 1'b0;
    xfer          = rd_valid_q && rd_ready;
    load_en       = !rd_valid_q || rd_ready;
    // The head entry leaves only once its high half has been accepted
    fifo_pop      = xfer && (out_kind_q == OUT_HI);

    case (state_q)
      ST_IDLE: begin
        if (arm && (cfg_length != '0)) begin
          state_d      = ST_ARMED;
          start_time_d = cfg_start_time;
          length_d     = cfg_length;
          beat_cnt_d   = '0;
          dropped_d    = '0;
          ovf_err_d    = 1'b0;
          ts_err_d     = (counter > cfg_start_time);
        end
      end
      ST_ARMED: begin
        if (s00_axis_tvalid && (counter >= start_time_q)) begin
          state_d       = ST_CAPTURE;
          hdr_d         = OUT_WIDTH'(make_header(counter, HDR_LEN_W'(length_q)));
          hdr_pending_d = 1'b1;
          take_beat     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (beat_cnt_q == length_q) begin
          state_d = ST_DRAIN;
        end else if (s00_axis_tvalid) begin
          take_beat = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && (fifo_count == CNT_W'(1)) && !hdr_pending_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every consumed beat counts toward the length, stored or not
    if (take_beat) begin
      beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        ovf_err_d = 1'b1;
        if (dropped_q != '1) dropped_d = dropped_q + LEN_WIDTH'(1);
      end
    end

    // Refill the output register whenever it is empty or being accepted
    if (load_en) begin
      rd_valid_d = 1'b0;
      out_kind_d = OUT_NONE;
      if (hdr_pending_q) begin
        rd_data_d     = hdr_q;
        rd_valid_d    = 1'b1;
        out_kind_d    = OUT_HDR;
        hdr_pending_d = 1'b0;
      end else if (out_kind_q == OUT_LO) begin
        rd_data_d  = fifo_rdata[AXIS_DATA_WIDTH-1:OUT_WIDTH];
        rd_valid_d = 1'b1;
        out_kind_d = OUT_HI;
      end else if (out_kind_q == OUT_HI) begin
        // Head is popping this cycle, so the next low half comes from behind it
        if (fifo_count >= CNT_W'(2)) begin
          rd_data_d  = fifo_rdata_next;
          rd_valid_d = 1'b1;
          out_kind_d = OUT_LO;
        end
      end else if (!fifo_empty) begin
        rd_data_d  = fifo_rdata[OUT_WIDTH-1:0];
        rd_valid_d = 1'b1;
        out_kind_d = OUT_LO;
      end
    end

    if (flush) begin
      state_d       = ST_IDLE;
      hdr_pending_d = 1'b0;
      rd_valid_d    = 1'b0;
      out_kind_d    = OUT_NONE;
      done_d        = 1'b0;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= ST_IDLE;
      out_kind_q    <= OUT_NONE;
      start_time_q  <= '0;
      length_q      <= '0;
      beat_cnt_q    <= '0;
      dropped_q     <= '0;
      hdr_q         <= '0;
      hdr_pending_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      tready_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ts_err_q      <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_kind_q    <= out_kind_d;
      start_time_q  <= start_time_d;
      length_q      <= length_d;
      beat_cnt_q    <= beat_cnt_d;
      dropped_q     <= dropped_d;
      hdr_q         <= hdr_d;
      hdr_pending_q <= hdr_pending_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      tready_q      <= tready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ts_err_q      <= ts_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timestamp_error = ts_err_q;
  assign overflow_error  = ovf_err_q;
  assign dropped_count   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_controller
// Description : Directed self-checking bench for adc_capture_controller with
//               a scoreboard of expected reader words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_controller;

  localparam int AXW   = 256;
  localparam int OW    = 128;
  localparam int DEPTH = 64;
  localparam int LW    = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [63:0]    counter;
  logic [63:0]    cfg_start_time;
  logic [LW-1:0]  cfg_length;
  logic           arm, flush;
  logic [AXW-1:0] tdata;
  logic           tvalid, tready;
  logic [OW-1:0]  rd_data;
  logic           rd_valid, rd_ready;
  logic           busy, done, ts_err, ovf_err;
  logic [LW-1:0]  dropped;

  logic [OW-1:0]  sb[$];
  int             checks   = 0;
  int             errors   = 0;
  int             done_cnt = 0;
  int             rdy_mode = 0;   // 0: always ready, 1: toggle, 2: never
  logic           prev_stall = 1'b0;
  logic [OW-1:0]  prev_data  = '0;

  always #5 clk = ~clk;

  adc_capture_controller #(
    .AXIS_DATA_WIDTH (AXW),
    .OUT_WIDTH       (OW),
    .FIFO_DEPTH      (DEPTH),
    .LEN_WIDTH       (LW)
  ) dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .counter         (counter),
    .cfg_start_time  (cfg_start_time),
    .cfg_length      (cfg_length),
    .arm             (arm),
    .flush           (flush),
    .s00_axis_tdata  (tdata),
    .s00_axis_tvalid (tvalid),
    .s00_axis_tready (tready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .busy            (busy),
    .done            (done),
    .timestamp_error (ts_err),
    .overflow_error  (ovf_err),
    .dropped_count   (dropped)
  );

  function automatic logic [AXW-1:0] beat(input logic [63:0] c);
    return {64'hF000_0000_0000_0000 ^ c, 64'hE000_0000_0000_0000 ^ c,
            64'hD000_0000_0000_0000 ^ c, 64'hC000_0000_0000_0000 ^ c};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected reader words for one capture window
  task automatic push_capture(input logic [63:0] ts, input logic [15:0] len, input int nbeats);
    logic [AXW-1:0] b;
    sb.push_back({ts, len, 48'h0});
    for (int i = 0; i < nbeats; i++) begin
      b = beat(ts + 64'(i));
      sb.push_back(b[OW-1:0]);
      sb.push_back(b[AXW-1:OW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 64'd1;
    tdata   = beat(counter);
    case (rdy_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'b0;
    endcase
  endtask

  task automatic set_counter(input logic [63:0] v);
    counter = v;
    tdata   = beat(v);
  endtask

  task automatic do_arm(input logic [63:0] st, input logic [LW-1:0] len);
    cfg_start_time = st;
    cfg_length     = len;
    arm            = 1'b1;
    tick();
    arm            = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < max) begin
      tick();
      n++;
    end
    repeat (3) tick();
    @(negedge clk);
    check({tag, "_done_once"}, OW'(done_cnt - d0), OW'(1));
    check({tag, "_sb_empty"}, OW'(sb.size()), OW'(0));
  endtask

  // Reader-side monitor: scoreboard compare, stall stability, done counting
  always @(negedge clk) begin
    logic [OW-1:0] exp;
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid", OW'(rd_valid), OW'(1));
        check("stall_data", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        check("word_expected", OW'(sb.size() != 0), OW'(1));
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("rd_word", rd_data, exp);
        end
      end
      if (done === 1'b1) done_cnt++;
      prev_stall = rd_valid && !rd_ready && !flush;
      prev_data  = rd_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    arm            = 1'b0;
    flush          = 1'b0;
    cfg_start_time = '0;
    cfg_length     = '0;
    tvalid         = 1'b1;
    rd_ready       = 1'b1;
    set_counter(64'd0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", OW'(tready), OW'(0));
    check("rst_rd_valid", OW'(rd_valid), OW'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_done", OW'(done), OW'(0));
    check("rst_ts_err", OW'(ts_err), OW'(0));
    check("rst_ovf_err", OW'(ovf_err), OW'(0));
    check("rst_dropped", OW'(dropped), OW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("tready_after_reset", OW'(tready), OW'(1));

    // Normal capture
    rdy_mode = 0;
    set_counter(64'd995);
    push_capture(64'd1000, 16'd4, 4);
    do_arm(64'd1000, LW'(4));
    @(negedge clk);
    check("normal_busy", OW'(busy), OW'(1));
    wait_done(100, "normal");
    check("normal_ts_err", OW'(ts_err), OW'(0));
    check("normal_ovf_err", OW'(ovf_err), OW'(0));
    check("normal_busy_end", OW'(busy), OW'(0));

    // Late start
    set_counter(64'd80);
    push_capture(64'd81, 16'd2, 2);
    do_arm(64'd50, LW'(2));
    @(negedge clk);
    check("late_ts_err", OW'(ts_err), OW'(1));
    wait_done(100, "late");

    // Overflow with the reader stalled for the whole window
    rdy_mode = 2;
    set_counter(64'd2000);
    push_capture(64'd2005, 16'd100, DEPTH);
    do_arm(64'd2005, LW'(100));
    @(negedge clk);
    check("ovf_ts_err_cleared", OW'(ts_err), OW'(0));
    repeat (110) tick();
    @(negedge clk);
    check("ovf_flag", OW'(ovf_err), OW'(1));
    check("ovf_dropped", OW'(dropped), OW'(36));
    rdy_mode = 0;
    wait_done(400, "ovf");
    check("ovf_flag_kept", OW'(ovf_err), OW'(1));

    // Reader stalls every other cycle
    rdy_mode = 1;
    set_counter(64'd3000);
    push_capture(64'd3002, 16'd6, 6);
    do_arm(64'd3002, LW'(6));
    wait_done(200, "stall");
    rdy_mode = 0;

    // Flush after 3 of 10 beats (late arm so the error flag must survive)
    rdy_mode = 2;
    set_counter(64'd4000);
    do_arm(64'd3990, LW'(10));
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", OW'(busy), OW'(0));
    check("flush_rd_valid", OW'(rd_valid), OW'(0));
    check("flush_ts_err_kept", OW'(ts_err), OW'(1));
    begin
      int d0;
      d0 = done_cnt;
      repeat (5) tick();
      @(negedge clk);
      check("flush_no_done", OW'(done_cnt - d0), OW'(0));
      check("flush_idle_rd_valid", OW'(rd_valid), OW'(0));
    end
    rdy_mode = 0;
    set_counter(64'd5000);
    push_capture(64'd5002, 16'd3, 3);
    do_arm(64'd5002, LW'(3));
    @(negedge clk);
    check("post_flush_ts_err", OW'(ts_err), OW'(0));
    wait_done(100, "post_flush");

    // Guards: zero length, then arm while busy
    set_counter(64'd6000);
    do_arm(64'd6000, LW'(0));
    repeat (4) tick();
    @(negedge clk);
    check("len0_busy", OW'(busy), OW'(0));
    check("len0_rd_valid", OW'(rd_valid), OW'(0));
    push_capture(64'd6010, 16'd5, 5);
    do_arm(64'd6010, LW'(5));
    repeat (12) tick();
    @(negedge clk);
    check("guard_busy_before_rearm", OW'(busy), OW'(1));
    do_arm(64'd6000, LW'(7));
    wait_done(100, "guard");
    repeat (20) tick();
    @(negedge clk);
    check("guard_quiet_rd_valid", OW'(rd_valid), OW'(0));
    check("guard_quiet_busy", OW'(busy), OW'(0));
    check("guard_ts_err", OW'(ts_err), OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
